hc_sr_trig: RTL
===============

Name: hc_sr_trig

Overview:
Measurement controller for the HC-SR04 ultrasonic ranger. It issues the 10 us trigger pulse and waits for the sensor's echo pulse. It times the echo in microseconds and enforces the sensor's minimum repetition period. It sits beside the echo-distance converter, drives the sensor's trig pin, and supplies a raw echo width plus done/timeout strobes to the obstacle-avoidance logic.

Parameters:
CLK_FREQ_MHZ, 50, system clock in MHz; sets the 1 us tick divider.
TRIG_US, 10, trigger pulse width in us.
WAIT_US, 5000, maximum wait in us from trigger fall to echo rise.
ECHO_MAX_US, 38000, maximum accepted echo width in us.
PERIOD_US, 60000, minimum us from one trigger rise to the next. Must exceed TRIG_US+WAIT_US+ECHO_MAX_US.

Ports:
Clk  in  1  system clock, 50 MHz
Rst  in  1  synchronous, active-high reset
en  in  1  auto mode: while high, measure back-to-back at PERIOD_US spacing
start  in  1  single-shot request, one-cycle pulse; ignored while busy
echo  in  1  sensor echo pin, asynchronous
trig  out  1  sensor trigger pin, registered
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle strobe when a valid echo width is latched
timeout  out  1  one-cycle strobe when echo rise or echo fall timed out
echo_us  out  16  last echo width in us

Behaviour:
- One clock domain (Clk), synchronous active-high reset (Rst); reset is sampled only on Clk rising edges.
- Reset values: trig=0, busy=0, done=0, timeout=0, echo_us=0, state=IDLE. All counters are cleared.
- Reset mid-operation aborts the measurement. trig is 0 from the first edge with Rst high. No done or timeout is produced.
- echo passes through a 2-flop synchronizer (echo_s), plus one registered copy for edge detection.
- us_tick: a divider counts 0..CLK_FREQ_MHZ-1 and pulses for one cycle at the terminal count. The divider and us_cnt clear on every state entry, so state durations are exact multiples of CLK_FREQ_MHZ clocks.
- per_cnt: 16-bit us counter. It clears on TRIG entry and counts every us_tick, saturating at 0xFFFF.
- FSM states and transitions:
  IDLE: trig=0. If en or start is high, go to TRIG. en has priority; both high gives a single measurement.
  TRIG: trig=1 for exactly TRIG_US*CLK_FREQ_MHZ cycles (500 at defaults), then go to WAIT_RISE.
  WAIT_RISE: trig=0. Only a 0->1 edge of echo_s counts; an echo already high on entry is ignored until it drops.
    - On the edge, go to MEASURE with us_cnt=0.
    - If us_cnt reaches WAIT_US, pulse timeout, set echo_us=16'hFFFF, go to HOLDOFF.
  MEASURE: us_cnt counts us_tick.
    - On the 1->0 edge of echo_s, set echo_us=us_cnt, pulse done, go to HOLDOFF.
    - If us_cnt reaches ECHO_MAX_US first, pulse timeout, set echo_us=ECHO_MAX_US, go to HOLDOFF. No done.
  HOLDOFF: stay until per_cnt >= PERIOD_US-1 with us_tick, then go to IDLE. From IDLE, en re-triggers after one cycle.
- done and timeout are mutually exclusive, one cycle wide, and asserted the cycle echo_us updates.
- echo_us holds its value between measurements.
- Latency: done asserts 3 Clk cycles after the echo falling edge at the pin. Width resolution is +/-1 us.
- Dropping en mid-cycle completes the current measurement, then the block stays in IDLE.
- start pulses while busy are dropped and not queued.
- An echo falling edge in the same cycle as us_cnt reaching ECHO_MAX_US is treated as done, not timeout.

Decomposition:
- Shared package: FSM state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF) and the echo_us rise-timeout code 16'hFFFF. Both constants are also used by the echo-distance converter.
- Sub-module us_tick_gen, parameter CLK_FREQ_MHZ, with a clear input and a tick output. It is reusable elsewhere for 1 us timing.

Test Plan:
- Reset, then one start pulse -> trig high for exactly 500 cycles, busy=1, trig low after.
- Echo rises 200 us after trig falls and stays high 1000 us -> echo_us=1000 (+/-1), done one cycle, 3 cycles after the echo fall.
- No echo after trig -> timeout after 5000 us, echo_us=16'hFFFF, no done, then HOLDOFF until 60000 us from trig rise.
- Echo held high 40000 us -> timeout at 38000 us, echo_us=38000, no done.
- en held high -> trig rising edges spaced 60000 us + 1 cycle apart. Drop en mid-MEASURE -> current result delivered, then no further trig.
- Assert Rst mid-MEASURE -> next edge trig=0, busy=0, echo_us=0. A start pulse during busy is ignored; a start pulse after reset begins a clean cycle.

Source files
------------

// File: rtl/hc_sr_trig_pkg.sv
// Shared definitions for the HC-SR04 measurement controller and the
// echo-distance converter that consumes its results.
package hc_sr_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } hc_state_e;

    // echo_us value reported when the echo never rose.
    localparam logic [15:0] ECHO_RISE_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/us_tick_gen.sv
// Free-running 1 us tick divider with a synchronous clear, so that a timed
// interval started with clear_i lasts an exact multiple of CLK_FREQ_MHZ clocks.
module us_tick_gen #(
    parameter int CLK_FREQ_MHZ = 50
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               DIV_W    = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ_MHZ - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_o = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DIV_ONE;
        if (clear_i || tick_o) begin
            div_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/hc_sr_trig.sv
// HC-SR04 measurement controller: issues the trigger pulse, times the echo in
// microseconds and enforces the minimum trigger-to-trigger period.
module hc_sr_trig
    import hc_sr_trig_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int TRIG_US      = 10,
    parameter int WAIT_US      = 5000,
    parameter int ECHO_MAX_US  = 38000,
    parameter int PERIOD_US    = 60000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        en,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] echo_us
);

    localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_US - 1);
    localparam logic [15:0] ECHO_LAST = 16'(ECHO_MAX_US - 1);
    localparam logic [15:0] ECHO_MAX  = 16'(ECHO_MAX_US);
    localparam logic [15:0] PER_LAST  = 16'(PERIOD_US - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;
    localparam logic [15:0] ONE_US    = 16'd1;

    hc_state_e   state_q, state_d;
    logic        echo_meta_q, echo_s_q, echo_prev_q;
    logic        echo_rise, echo_fall;
    logic        us_tick, state_entry;
    logic [15:0] us_cnt_q, us_cnt_d, us_inc;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] echo_us_q, echo_us_d;
    logic        trig_q, trig_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    assign echo_rise   = echo_s_q & ~echo_prev_q;
    assign echo_fall   = ~echo_s_q & echo_prev_q;
    assign state_entry = (state_d != state_q);
    assign us_inc      = us_tick ? us_cnt_q + ONE_US : us_cnt_q;

    us_tick_gen #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
    ) u_us_tick (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear_i(state_entry),
        .tick_o (us_tick)
    );

    // NOTE: every state-holding register is written with <= in one always_ff,
    // so all of them see the same pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
            us_cnt_q    <= '0;
            per_cnt_q   <= '0;
            echo_us_q   <= '0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            echo_prev_q <= echo_s_q;
            us_cnt_q    <= us_cnt_d;
            per_cnt_q   <= per_cnt_d;
            echo_us_q   <= echo_us_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    // Limits are tested on the tick that would make us_cnt reach them, so
    // timed exits land on a tick boundary and no partial microsecond is lost.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        echo_us_d = echo_us_q;
        case (state_q)
            ST_IDLE: begin
                if (en || start) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (us_tick && us_cnt_q == TRIG_LAST) state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                end else if (us_tick && us_cnt_q == WAIT_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    echo_us_d = ECHO_RISE_TIMEOUT;
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_d   = ST_HOLDOFF;
                    done_d    = 1'b1;
                    echo_us_d = us_inc;
                end else if (us_tick && us_cnt_q == ECHO_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    echo_us_d = ECHO_MAX;
                end
            end
            ST_HOLDOFF: begin
                if (us_tick && per_cnt_q >= PER_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        us_cnt_d = us_inc;
        if (state_entry || state_q == ST_IDLE) begin
            us_cnt_d = '0;
        end
        per_cnt_d = per_cnt_q;
        if (state_d == ST_TRIG && state_q != ST_TRIG) begin
            per_cnt_d = '0;
        end else if (us_tick && per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + ONE_US;
        end
    end

    always_comb begin
        trig_d = (state_d == ST_TRIG);
        busy   = (state_q != ST_IDLE);
    end

    assign trig    = trig_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign echo_us = echo_us_q;

endmodule
